// File: rtl/cga_slot_sequencer_pkg.sv
// Shared constants and helpers for the CGA slot sequencer: strobe offsets within a slot
// and fetch-mode clamping.
package cga_seq_pkg;

    localparam int OFS_CRTC      = 0;
    localparam int OFS_RD_FIRST  = 1;
    localparam int OFS_RD_LAST   = 3;
    localparam int OFS_A0        = 2;
    localparam int OFS_CHAR      = 2;
    localparam int OFS_ATT       = 3;
    localparam int OFS_PIPE      = 4;
    localparam int OFS_ISA_FIRST = 5;

    // Slots with no VRAM fetch open the ISA window right after the CRTC tick.
    localparam int OFS_ISA_FIRST_IDLE = 1;

    function automatic int clamp_mode(input int mode, input int slot_bits);
        return (mode > slot_bits) ? slot_bits : mode;
    endfunction

    function automatic int mode_width(input int slot_bits);
        return (slot_bits < 2) ? 1 : $clog2(slot_bits + 1);
    endfunction

endpackage

// File: rtl/cga_slot_sequencer_if.sv
// Host-facing bundle of the slot sequencer: fetch-mode select, ISA handshake and timing strobes.
// master = host/requester side, slave = sequencer side.
interface cga_slot_sequencer_if #(
    parameter int SEQ_BITS  = 5,
    parameter int SLOT_BITS = 1,
    parameter int MODE_W    = cga_seq_pkg::mode_width(SLOT_BITS)
);

    logic [MODE_W-1:0]    fetch_mode;
    logic                 isa_req;

    logic [SEQ_BITS-1:0]  clk_seq;
    logic [SLOT_BITS-1:0] slot_idx;
    logic                 lclk;
    logic                 hclk;
    logic                 crtc_clk;
    logic                 vram_read;
    logic                 vram_read_a0;
    logic                 vram_read_char;
    logic                 vram_read_att;
    logic                 charrom_read;
    logic                 disp_pipeline;
    logic                 isa_op_enable;
    logic                 isa_start;
    logic                 isa_busy;
    logic                 isa_ack;

    modport master (
        output fetch_mode, isa_req,
        input  clk_seq, slot_idx, lclk, hclk, crtc_clk,
        input  vram_read, vram_read_a0, vram_read_char, vram_read_att,
        input  charrom_read, disp_pipeline,
        input  isa_op_enable, isa_start, isa_busy, isa_ack
    );

    modport slave (
        input  fetch_mode, isa_req,
        output clk_seq, slot_idx, lclk, hclk, crtc_clk,
        output vram_read, vram_read_a0, vram_read_char, vram_read_att,
        output charrom_read, disp_pipeline,
        output isa_op_enable, isa_start, isa_busy, isa_ack
    );

endinterface

// File: rtl/cga_slot_sequencer_arbiter.sv
// ISA access arbiter: grants a request inside the slot's ISA window and times the op
// with a busy down-counter, pulsing ack on the final busy cycle.
module cga_isa_slot_arbiter
    import cga_seq_pkg::*;
#(
    parameter int OP_LEN = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic window_i,
    input  logic isa_req_i,
    output logic op_enable_o,
    output logic start_o,
    output logic busy_o,
    output logic ack_o
);

    localparam int CW = (OP_LEN < 2) ? 1 : $clog2(OP_LEN + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // cnt_q counts the busy cycles still to come after the start cycle, so the
    // enable never depends on this cycle's start (no loop through isa_req).
    always_comb begin
        op_enable_o = !reset && window_i && (cnt_q == '0);
        start_o     = isa_req_i && op_enable_o;
        busy_o      = !reset && (start_o || (cnt_q != '0));
        if (OP_LEN == 1) begin
            ack_o = start_o;
        end else begin
            ack_o = !reset && (cnt_q == CW'(1));
        end

        cnt_d = cnt_q;
        if (start_o) begin
            cnt_d = CW'(OP_LEN - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cga_slot_sequencer.sv
// CGA slot sequencer: free-running period counter split into equal slots, per-slot VRAM/char-ROM/
// CRTC strobes with period-aligned fetch density, and a windowed ISA req/start/ack handshake.
module cga_slot_sequencer
    import cga_seq_pkg::*;
#(
    parameter int SEQ_BITS   = 5,
    parameter int SLOT_BITS  = 1,
    parameter int ISA_OP_LEN = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    cga_slot_sequencer_if.slave  bus
);

    localparam int PERIOD   = 2 ** SEQ_BITS;
    localparam int NSLOT    = 2 ** SLOT_BITS;
    localparam int L        = PERIOD >> SLOT_BITS;
    localparam int LB       = SEQ_BITS - SLOT_BITS;
    localparam int MODE_W   = mode_width(SLOT_BITS);
    localparam int WIN_LAST = L - ISA_OP_LEN + 1;
    localparam logic [SEQ_BITS-1:0] LAST_TICK = '1;

    if (SLOT_BITS < 1) begin : g_bad_slots
        $error("cga_slot_sequencer: SLOT_BITS must be at least 1");
    end
    if (L < 8) begin : g_bad_len
        $error("cga_slot_sequencer: slot length PERIOD>>SLOT_BITS must be at least 8");
    end
    if ((ISA_OP_LEN < 1) || (ISA_OP_LEN > L - 6)) begin : g_bad_op
        $error("cga_slot_sequencer: ISA_OP_LEN must lie in 1..L-6");
    end

    logic [SEQ_BITS-1:0]  clkdiv_q;
    logic [SEQ_BITS-1:0]  clkdiv_d;
    logic [MODE_W-1:0]    mode_q;
    logic [MODE_W-1:0]    mode_d;
    logic [MODE_W-1:0]    mode_sel;

    logic [SLOT_BITS-1:0] slot;
    logic [SLOT_BITS-1:0] act_mask;
    logic [LB-1:0]        ofs;
    int                   ofs_n;
    logic                 run;
    logic                 active;
    logic                 window;

    logic lclk, hclk, crtc, vrd, rd_a0, rd_char, rd_att, crom, pipe;
    logic isa_en, isa_start, isa_busy, isa_ack;

    // Density is only adopted on the last tick so a whole period always sees one mode.
    always_comb begin
        mode_sel = MODE_W'(clamp_mode(int'(bus.fetch_mode), SLOT_BITS));
        clkdiv_d = clkdiv_q + 1'b1;
        mode_d   = mode_q;
        if (clkdiv_q == LAST_TICK) begin
            mode_d = mode_sel;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clkdiv_q <= '0;
            mode_q   <= mode_sel;
        end else begin
            clkdiv_q <= clkdiv_d;
            mode_q   <= mode_d;
        end
    end

    // Active slots are every (NSLOT >> mode)-th slot, i.e. slot index low bits all zero.
    always_comb begin
        run      = !reset;
        slot     = clkdiv_q[SEQ_BITS-1:LB];
        ofs      = clkdiv_q[LB-1:0];
        ofs_n    = int'(ofs);
        act_mask = SLOT_BITS'((NSLOT >> mode_q) - 1);
        active   = ((slot & act_mask) == '0);

        lclk     = run && (clkdiv_q == '0);
        hclk     = run && (ofs_n == OFS_CRTC);
        crtc     = hclk && active;
        vrd      = run && active && (ofs_n >= OFS_RD_FIRST) && (ofs_n <= OFS_RD_LAST);
        rd_a0    = run && active && (ofs_n == OFS_A0);
        rd_char  = run && active && (ofs_n == OFS_CHAR);
        rd_att   = run && active && (ofs_n == OFS_ATT);
        crom     = run && active && (ofs_n == OFS_ATT);
        pipe     = run && active && (ofs_n == OFS_PIPE);

        // The window ends early enough that the last op finishes on the next slot's o==0.
        window   = run && (ofs_n <= WIN_LAST) &&
                   (active ? (ofs_n >= OFS_ISA_FIRST) : (ofs_n >= OFS_ISA_FIRST_IDLE));
    end

    cga_isa_slot_arbiter #(
        .OP_LEN (ISA_OP_LEN)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .window_i    (window),
        .isa_req_i   (bus.isa_req),
        .op_enable_o (isa_en),
        .start_o     (isa_start),
        .busy_o      (isa_busy),
        .ack_o       (isa_ack)
    );

    assign bus.clk_seq        = run ? clkdiv_q : '0;
    assign bus.slot_idx       = run ? slot : '0;
    assign bus.lclk           = lclk;
    assign bus.hclk           = hclk;
    assign bus.crtc_clk       = crtc;
    assign bus.vram_read      = vrd;
    assign bus.vram_read_a0   = rd_a0;
    assign bus.vram_read_char = rd_char;
    assign bus.vram_read_att  = rd_att;
    assign bus.charrom_read   = crom;
    assign bus.disp_pipeline  = pipe;
    assign bus.isa_op_enable  = isa_en;
    assign bus.isa_start      = isa_start;
    assign bus.isa_busy       = isa_busy;
    assign bus.isa_ack        = isa_ack;

endmodule

// File: tb/tb_cga_slot_sequencer.sv
// Bench for cga_slot_sequencer: time-stamp behavioural model checked every cycle, plus
// directed scenarios with hand-computed per-period strobe masks.
module tb_cga_slot_sequencer;

    localparam int SEQ_BITS  = 5;
    localparam int SLOT_BITS = 1;
    localparam int LEN       = 3;
    localparam int PERIOD    = 32;
    localparam int NSLOT     = 2;
    localparam int L         = 16;

    logic clk = 1'b0;
    logic reset;

    cga_slot_sequencer_if #(.SEQ_BITS(SEQ_BITS), .SLOT_BITS(SLOT_BITS)) bus();

    cga_slot_sequencer #(
        .SEQ_BITS   (SEQ_BITS),
        .SLOT_BITS  (SLOT_BITS),
        .ISA_OP_LEN (LEN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Model state: counter value, mode in force, absolute cycle and last op start stamp.
    int m_cnt = 0;
    int m_mode = 0;
    int m_cyc = 0;
    int m_op_start = 0;
    bit m_op_valid = 1'b0;

    typedef struct {
        int seq;
        int slot;
        bit lclk, hclk, crtc, vr, a0, ch, att, cr, pipe, en, st, busy, ack;
    } exp_t;

    function automatic int clampm(input int m);
        return (m > SLOT_BITS) ? SLOT_BITS : m;
    endfunction

    function automatic exp_t model(input bit rst, input bit req);
        exp_t e;
        int k, o, since;
        bit act, win, inop;
        e = '{seq: 0, slot: 0, default: 1'b0};
        if (!rst) begin
            k      = m_cnt / L;
            o      = m_cnt % L;
            act    = (k % (NSLOT >> m_mode)) == 0;
            e.seq  = m_cnt;
            e.slot = k;
            e.lclk = (m_cnt == 0);
            e.hclk = (o == 0);
            e.crtc = act && (o == 0);
            e.vr   = act && (o >= 1) && (o <= 3);
            e.a0   = act && (o == 2);
            e.ch   = act && (o == 2);
            e.att  = act && (o == 3);
            e.cr   = act && (o == 3);
            e.pipe = act && (o == 4);
            win    = (o <= L - LEN + 1) && (act ? (o >= 5) : (o >= 1));
            since  = m_cyc - m_op_start;
            inop   = m_op_valid && (since < LEN);
            e.en   = win && !inop;
            e.st   = req && e.en;
            e.busy = inop || e.st;
            e.ack  = e.st ? (LEN == 1) : (inop && (since == LEN - 1));
        end
        return e;
    endfunction

    always @(posedge clk) begin : model_step
        exp_t e;
        e = model(reset, bus.isa_req);
        if (reset) begin
            m_cnt      = 0;
            m_mode     = clampm(int'(bus.fetch_mode));
            m_op_valid = 1'b0;
        end else begin
            if (e.st) begin
                m_op_valid = 1'b1;
                m_op_start = m_cyc;
            end
            if (m_cnt == PERIOD - 1) m_mode = clampm(int'(bus.fetch_mode));
            m_cnt = (m_cnt + 1) % PERIOD;
        end
        m_cyc++;
    end

    always @(negedge clk) begin : compare
        exp_t e;
        string c;
        e = model(reset, bus.isa_req);
        c = $sformatf("cyc%0d ", m_cyc);
        chk({c, "clk_seq"},        32'(bus.clk_seq),        32'(e.seq));
        chk({c, "slot_idx"},       32'(bus.slot_idx),       32'(e.slot));
        chk({c, "lclk"},           32'(bus.lclk),           32'(e.lclk));
        chk({c, "hclk"},           32'(bus.hclk),           32'(e.hclk));
        chk({c, "crtc_clk"},       32'(bus.crtc_clk),       32'(e.crtc));
        chk({c, "vram_read"},      32'(bus.vram_read),      32'(e.vr));
        chk({c, "vram_read_a0"},   32'(bus.vram_read_a0),   32'(e.a0));
        chk({c, "vram_read_char"}, 32'(bus.vram_read_char), 32'(e.ch));
        chk({c, "vram_read_att"},  32'(bus.vram_read_att),  32'(e.att));
        chk({c, "charrom_read"},   32'(bus.charrom_read),   32'(e.cr));
        chk({c, "disp_pipeline"},  32'(bus.disp_pipeline),  32'(e.pipe));
        chk({c, "isa_op_enable"},  32'(bus.isa_op_enable),  32'(e.en));
        chk({c, "isa_start"},      32'(bus.isa_start),      32'(e.st));
        chk({c, "isa_busy"},       32'(bus.isa_busy),       32'(e.busy));
        chk({c, "isa_ack"},        32'(bus.isa_ack),        32'(e.ack));
    end

    typedef struct {
        logic [31:0] lclk, hclk, crtc, vram, en, st, busy, ack;
    } mask_t;

    // Records one bit per clk_seq value, from the next falling edge up to clk_seq == stop.
    task automatic collect(input int stop, output mask_t m);
        bit done;
        int idx;
        done = 1'b0;
        m = '{default: '0};
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk);
            idx          = int'(bus.clk_seq);
            m.lclk[idx]  = bus.lclk;
            m.hclk[idx]  = bus.hclk;
            m.crtc[idx]  = bus.crtc_clk;
            m.vram[idx]  = bus.vram_read;
            m.en[idx]    = bus.isa_op_enable;
            m.st[idx]    = bus.isa_start;
            m.busy[idx]  = bus.isa_busy;
            m.ack[idx]   = bus.isa_ack;
            if (idx == stop) done = 1'b1;
        end
        chk($sformatf("collect_to_%0d reached", stop), 32'(done), 32'd1);
    endtask

    // Leaves the caller just after the rising edge that starts the cycle with clk_seq == s.
    task automatic at_seq(input int s);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(posedge clk);
            #1;
            if (int'(bus.clk_seq) == s) found = 1'b1;
        end
        chk($sformatf("at_seq_%0d reached", s), 32'(found), 32'd1);
    endtask

    initial begin : stim
        mask_t m;
        reset          = 1'b1;
        bus.fetch_mode = 1'b1;
        bus.isa_req    = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Full density: both slots fetch.
        collect(31, m);
        chk("t1 lclk",      m.lclk, 32'h0000_0001);
        chk("t1 hclk",      m.hclk, 32'h0001_0001);
        chk("t1 crtc_clk",  m.crtc, 32'h0001_0001);
        chk("t1 vram_read", m.vram, 32'h000E_000E);
        chk("t1 isa_en",    m.en,   32'h7FE0_7FE0);

        // Half density from the next period on.
        bus.fetch_mode = 1'b0;
        collect(31, m);
        chk("t2 hclk",      m.hclk, 32'h0001_0001);
        chk("t2 crtc_clk",  m.crtc, 32'h0000_0001);
        chk("t2 vram_read", m.vram, 32'h0000_000E);
        chk("t2 isa_en",    m.en,   32'h7FFE_7FE0);

        // Request before the window, held across the first ack.
        at_seq(3);
        bus.isa_req = 1'b1;
        collect(10, m);
        chk("t3 isa_start", m.st,   32'h0000_0120);
        chk("t3 isa_busy",  m.busy, 32'h0000_07E0);
        chk("t3 isa_ack",   m.ack,  32'h0000_0480);
        chk("t3 isa_en",    m.en,   32'h0000_0120);
        at_seq(11);
        bus.isa_req = 1'b0;

        // Last legal start, then a request just past the window.
        bus.fetch_mode = 1'b1;
        at_seq(0);
        at_seq(14);
        bus.isa_req = 1'b1;
        collect(16, m);
        chk("t4a isa_start", m.st,   32'h0000_4000);
        chk("t4a isa_busy",  m.busy, 32'h0001_C000);
        chk("t4a isa_ack",   m.ack,  32'h0001_0000);
        at_seq(17);
        bus.isa_req = 1'b0;
        at_seq(15);
        bus.isa_req = 1'b1;
        collect(23, m);
        chk("t4b isa_start", m.st,   32'h0020_0000);
        chk("t4b isa_busy",  m.busy, 32'h00E0_0000);
        chk("t4b isa_ack",   m.ack,  32'h0080_0000);
        chk("t4b isa_en",    m.en,   32'h0020_0000);
        chk("t4b vram_read", m.vram, 32'h000E_0000);
        at_seq(24);
        bus.isa_req = 1'b0;

        // Mode change mid-period takes effect only at the next period.
        at_seq(10);
        bus.fetch_mode = 1'b0;
        collect(31, m);
        chk("t5 crtc_clk cur",  m.crtc, 32'h0001_0000);
        chk("t5 vram_read cur", m.vram, 32'h000E_0000);
        collect(31, m);
        chk("t5 crtc_clk next",  m.crtc, 32'h0000_0001);
        chk("t5 vram_read next", m.vram, 32'h0000_000E);

        // Reset in the middle of an op.
        at_seq(5);
        bus.isa_req = 1'b1;
        at_seq(6);
        reset          = 1'b1;
        bus.fetch_mode = 1'b1;
        @(negedge clk);
        chk("t6 busy in reset",    32'(bus.isa_busy),      32'd0);
        chk("t6 ack in reset",     32'(bus.isa_ack),       32'd0);
        chk("t6 en in reset",      32'(bus.isa_op_enable), 32'd0);
        chk("t6 clk_seq in reset", 32'(bus.clk_seq),       32'd0);
        chk("t6 lclk in reset",    32'(bus.lclk),          32'd0);
        chk("t6 hclk in reset",    32'(bus.hclk),          32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        bus.isa_req = 1'b0;
        collect(31, m);
        chk("t6 lclk after",  m.lclk, 32'h0000_0001);
        chk("t6 crtc after",  m.crtc, 32'h0001_0001);
        chk("t6 start after", m.st,   32'h0000_0000);
        chk("t6 ack after",   m.ack,  32'h0000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
